b11_trace_capture: RTL
======================

# b11_trace_capture

Capture stage that sits directly downstream of the b11 core in the concolic test harness. It watches the core's `x_out` result and the `__obs` marker every cycle, and logs each change as a timestamped record into a small FIFO. The trace host drains that FIFO over a valid/ready handshake. The stimulus program can run without stalling, while the host reads the output trace at its own pace.

## Interface
Parameters:
- `DATA_W`, 6: width of the observed `x_out` bus.
- `TS_W`, 16: timestamp counter width.
- `DEPTH`, 16: FIFO entries; power of two, ≥ 2.

Ports:
- `clock`, in, 1: single clock; all state updates on its rising edge.
- `reset`, in, 1: asynchronous, active-high; clears all state.
- `arm`, in, 1: single-cycle pulse; starts a capture window.
- `stop`, in, 1: single-cycle pulse; ends the capture window.
- `x_out`, in, `DATA_W`: b11 result bus being observed.
- `obs`, in, 1: `__obs` marker bit, sampled alongside `x_out`.
- `rec_valid`, out, 1: FIFO head record is valid.
- `rec_ready`, in, 1: host accepts the head record.
- `rec_data`, out, `TS_W+1+DATA_W`: record `{ts, obs, x_out}`. Width is `1+DATA_W` when timestamps are compiled out.
- `capturing`, out, 1: high while in `CAPTURE`.
- `overflow`, out, 1: sticky; at least one record was dropped.
- `drop_cnt`, out, 8: count of dropped records; saturates at 255.
- `level`, out, `$clog2(DEPTH)+1`: current FIFO occupancy.

## Operation
- FSM states: `IDLE`, `CAPTURE`, `DONE`.
  - `IDLE`, `arm` asserted → `CAPTURE`. Timestamp is cleared to 0 and the first-sample flag is set.
  - `CAPTURE`, `stop` asserted → `DONE`. The sample taken in the same cycle as `stop` is still evaluated.
  - `DONE`, `arm` asserted → `CAPTURE`. This starts a new window; the FIFO contents are kept.
  - `arm` and `stop` asserted together: `arm` wins from `IDLE`/`DONE`; `stop` wins from `CAPTURE`.
- In `CAPTURE`, a push is requested when any of the following holds:
  - it is the first sample of the window;
  - `x_out` differs from the last pushed value;
  - `obs` is high and was low in the previous cycle (rising edge).
- The "last pushed value" register updates only on an accepted push.
- Record contents: the current `ts`, `obs` and `x_out` values, all taken on the same edge.
- Timestamp counts every `CAPTURE` cycle and saturates at all-ones; it never wraps.
- FIFO is circular with `DEPTH` entries. Read and write pointers are one bit wider than the address, used for full/empty detection.
- Push request while the FIFO is full and no pop occurs in the same cycle:
  - the record is dropped;
  - `overflow` is set;
  - `drop_cnt` increments, saturating at 255.
- Push and pop in the same cycle while full: both succeed and `level` is unchanged.
- Push and pop in the same cycle while empty: the push succeeds and there is no pop.
- `overflow` and `drop_cnt` clear only on `reset` or on an `arm` accepted from `IDLE`/`DONE`.
- The host may pop in any state, including `IDLE` and `DONE`.

## Timing
- Reset values:
  - state is `IDLE`;
  - `rec_valid`, `capturing`, `overflow` are 0;
  - `drop_cnt`, `level`, `ts` are 0;
  - `rec_data` is 0.
- `capturing` goes high on the edge that samples `arm` and goes low on the edge that samples `stop`.
- A push evaluated at edge N is written at edge N:
  - `rec_valid` rises after edge N if the FIFO was empty;
  - `level` reflects the push after edge N.
- Pop: occurs on an edge where `rec_valid && rec_ready`. The next head record, or `rec_valid` = 0, is visible after that edge.
- `rec_data` is stable while `rec_valid` is high and `rec_ready` is low.
- Throughput: one push and one pop per cycle.
- Reset asserted mid-capture immediately empties the FIFO, drops `rec_valid` and returns the FSM to `IDLE`. This happens asynchronously and does not wait for a clock edge.

## Configuration
- Macro `B11_TRACE_TIMESTAMP_EN`.
- Defined:
  - `TS_W`-bit timestamp counter present;
  - `rec_data` is `{ts, obs, x_out}`, `TS_W+1+DATA_W` bits.
- Undefined:
  - no counter is built;
  - `rec_data` is `{obs, x_out}`, `1+DATA_W` bits;
  - all push, drop and handshake behaviour is identical to the defined case.

## Test plan
- Arm, then hold `x_out`=6'h05 for 4 cycles, then 6'h2A; `rec_ready`=1.
  - Expected: exactly 2 records, `{ts=0, 0, 05}` and `{ts=4, 0, 2A}`; `overflow`=0.
- `obs` goes 0→1→1→0→1 with `x_out` constant (after the first-sample record).
  - Expected: 2 extra records, at the two rising edges only.
- `rec_ready`=0; `x_out` changes on 20 consecutive cycles after arm, with `DEPTH`=16.
  - Expected: `level`=16, `overflow`=1, `drop_cnt`=4.
  - Then drain with `rec_ready`=1: 16 records with ts 0..15 in order.
- FIFO full with `rec_ready`=1 and a change in the same cycle.
  - Expected: push accepted, `level` stays 16, `drop_cnt` unchanged.
- Pulse `stop`, change `x_out`, then re-`arm`.
  - Expected: no push while in `DONE`; after re-arm the first record has ts=0, and `overflow` and `drop_cnt` are cleared.
- Assert `reset` between edges while `level`=5.
  - Expected: `rec_valid`=0, `level`=0, `capturing`=0 before the next edge.

Source files
------------

// File: rtl/b11_trace_capture_if.sv
// b11_trace_capture_if
// Groups the capture-control, observed-bus and trace-drain signals of the
// b11 trace capture stage.
//   slave  : the capture block (consumes arm/stop/x_out/obs/rec_ready)
//   master : harness / trace host side (drives arm/stop/x_out/obs/rec_ready)
// Record width depends on B11_TRACE_TIMESTAMP_EN: {ts, obs, x_out} when
// defined, {obs, x_out} otherwise.
interface b11_trace_capture_if #(
  parameter int DATA_W = 6,
  parameter int TS_W   = 16,
  parameter int DEPTH  = 16
);
`ifdef B11_TRACE_TIMESTAMP_EN
  localparam int TS_BITS = TS_W;
`else
  localparam int TS_BITS = 0 * TS_W;
`endif
  localparam int REC_W = TS_BITS + 1 + DATA_W;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic              arm;
  logic              stop;
  logic [DATA_W-1:0] x_out;
  logic              obs;
  logic              rec_valid;
  logic              rec_ready;
  logic [REC_W-1:0]  rec_data;
  logic              capturing;
  logic              overflow;
  logic [7:0]        drop_cnt;
  logic [LVL_W-1:0]  level;

  modport master (
    output arm, stop, x_out, obs, rec_ready,
    input  rec_valid, rec_data, capturing, overflow, drop_cnt, level
  );

  modport slave (
    input  arm, stop, x_out, obs, rec_ready,
    output rec_valid, rec_data, capturing, overflow, drop_cnt, level
  );
endinterface

// File: rtl/b11_trace_capture.sv
// b11_trace_capture
// Watches the b11 core's x_out result and __obs marker and logs every change
// as a record into a circular FIFO that a trace host drains via valid/ready.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous, active-high; clears all state
//   bus   : b11_trace_capture_if.slave (arm, stop, x_out, obs, rec_ready in;
//           rec_valid, rec_data, capturing, overflow, drop_cnt, level out)
// Build option: B11_TRACE_TIMESTAMP_EN adds a TS_W-bit saturating timestamp
// to each record ({ts, obs, x_out}); without it records are {obs, x_out}.
//
// state   | meaning
// IDLE    | no window since reset; waiting for arm
// CAPTURE | window open; every cycle is evaluated for a push
// DONE    | window closed by stop; FIFO kept, waiting for re-arm
module b11_trace_capture #(
  parameter int DATA_W = 6,
  parameter int TS_W   = 16,
  parameter int DEPTH  = 16
) (
  input  logic clock,
  input  logic reset,
  b11_trace_capture_if.slave bus
);
`ifdef B11_TRACE_TIMESTAMP_EN
  localparam int TS_BITS = TS_W;
`else
  localparam int TS_BITS = 0 * TS_W;
`endif
  localparam int REC_W = TS_BITS + 1 + DATA_W;
  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_arm_acc;
  logic              w_in_cap;

  logic              r_first;
  logic [DATA_W-1:0] r_last;
  logic              r_obs_prev;

  logic [LVL_W-1:0]  r_wr_ptr;
  logic [LVL_W-1:0]  r_rd_ptr;
  logic [REC_W-1:0]  r_mem [DEPTH];

  logic              r_overflow;
  logic [7:0]        r_drop_cnt;

  logic              w_empty;
  logic              w_full;
  logic              w_pop;
  logic              w_push_req;
  logic              w_push;
  logic              w_drop;
  logic [REC_W-1:0]  w_rec;

  // FSM
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_arm_acc   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.arm) begin
          w_state_nxt = CAPTURE;
          w_arm_acc   = 1'b1;
        end
      end
      CAPTURE: begin
        // arm is ignored here, so stop wins when both are pulsed
        if (bus.stop) w_state_nxt = DONE;
      end
      DONE: begin
        if (bus.arm) begin
          w_state_nxt = CAPTURE;
          w_arm_acc   = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_in_cap = (r_state == CAPTURE);

  // Push decision and FIFO status
  assign w_push_req = w_in_cap &&
                      (r_first || (bus.x_out != r_last) || (bus.obs && !r_obs_prev));

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = !w_empty && bus.rec_ready;
  // A pop on the same edge frees the slot the push lands in.
  assign w_push  = w_push_req && (!w_full || w_pop);
  assign w_drop  = w_push_req && w_full && !w_pop;

  // Timestamp
`ifdef B11_TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] r_ts;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                        r_ts <= '0;
    else if (w_arm_acc)               r_ts <= '0;
    else if (w_in_cap && (r_ts != '1)) r_ts <= r_ts + TS_W'(1);
  end

  assign w_rec = {r_ts, bus.obs, bus.x_out};
`else
  assign w_rec = {bus.obs, bus.x_out};
`endif

  // Change-detect state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_first    <= 1'b0;
      r_last     <= '0;
      r_obs_prev <= 1'b0;
    end else begin
      r_obs_prev <= bus.obs;
      if (w_arm_acc)     r_first <= 1'b1;
      else if (w_in_cap) r_first <= 1'b0;
      // dropped records do not count as "last pushed"
      if (w_push)        r_last  <= bus.x_out;
    end
  end

  // FIFO storage (no reset needed: reads are masked while empty)
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= w_rec;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + LVL_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + LVL_W'(1);
    end
  end

  // Drop bookkeeping; cleared only by reset or an accepted arm
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_arm_acc) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  // Outputs
  assign bus.rec_valid = !w_empty;
  assign bus.rec_data  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
  assign bus.level     = r_wr_ptr - r_rd_ptr;
  assign bus.capturing = w_in_cap;
  assign bus.overflow  = r_overflow;
  assign bus.drop_cnt  = r_drop_cnt;
endmodule
